// File: rtl/instr_loader.sv
// instr_loader: loads up to 16 instruction words from switches into a 16x16
// instruction memory, then hands the memory to the processor.
//
// Optional feature: define INSTR_LOADER_DEBOUNCE_EN to pass Load through a
// 2-flop synchronizer and a DB_CYCLES stability counter before edge detection.
//
// Ports:
//   Clock   in   rising-edge clock
//   Resetn  in   asynchronous active-low reset (clears memory too)
//   Load    in   key level; each accepted rising edge writes DIn
//   Start   in   ends filling early (ignored while EMPTY)
//   Clear   in   empties memory, highest priority
//   DIn     in   16-bit instruction word
//   pc      in   4-bit read address
//   Instr   out  mem[pc] while Ready, else 16'h0000
//   Count   out  number of words written, 0..16
//   Ready   out  registered, high in READY state
//   Ovf     out  sticky: press accepted while READY
module instr_loader #(
  parameter int unsigned DB_CYCLES = 8
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Load,
  input  logic        Start,
  input  logic        Clear,
  input  logic [15:0] DIn,
  input  logic [3:0]  pc,
  output logic [15:0] Instr,
  output logic [4:0]  Count,
  output logic        Ready,
  output logic        Ovf
);

  typedef enum logic [1:0] {EMPTY, FILLING, READY} state_t;

  state_t      state;
  logic [15:0] mem [16];
  logic [3:0]  wr_ptr;
  logic        load_lvl;
  logic        load_prev;
  logic        armed;
  logic        press;

`ifdef INSTR_LOADER_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          db_level;
  logic [CW-1:0] db_cnt;

  // The counter runs only while the synchronized level disagrees with the
  // debounced level; any return to agreement restarts it, so short glitches
  // never reach the edge detector.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1 <= Load;
      sync2 <= sync1;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign load_lvl = db_level;
`else
  assign load_lvl = Load;

  // DB_CYCLES only matters with debounce enabled.
  logic unused_db_cycles;
  assign unused_db_cycles = |DB_CYCLES;
`endif

  // armed stays low for the first edge after reset release so a key already
  // held down at that moment is not taken as a press.
  assign press = armed & load_lvl & ~load_prev;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= EMPTY;
      wr_ptr    <= '0;
      Count     <= '0;
      Ready     <= 1'b0;
      Ovf       <= 1'b0;
      load_prev <= 1'b0;
      armed     <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      armed     <= 1'b1;
      load_prev <= load_lvl;
      if (Clear) begin
        state  <= EMPTY;
        wr_ptr <= '0;
        Count  <= '0;
        Ready  <= 1'b0;
        Ovf    <= 1'b0;
        for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (press) begin
              mem[0] <= DIn;
              wr_ptr <= 4'd1;
              Count  <= 5'd1;
              state  <= FILLING;
            end
          end
          FILLING: begin
            if (press) begin
              mem[wr_ptr] <= DIn;
              wr_ptr      <= wr_ptr + 4'd1;
              Count       <= Count + 5'd1;
            end
            // A press coinciding with Start is written above before leaving.
            if (Start || (press && Count == 5'd15)) begin
              state <= READY;
              Ready <= 1'b1;
            end
          end
          READY: begin
            if (press) Ovf <= 1'b1;
          end
          default: begin
            state <= EMPTY;
            Ready <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    Instr = '0;
    if (Ready) Instr = mem[pc];
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  localparam int unsigned DB = 8;
`ifdef INSTR_LOADER_DEBOUNCE_EN
  localparam int LAT    = 2 + DB;
  localparam int SETTLE = DB + 6;
`else
  localparam int LAT    = 0;
  localparam int SETTLE = 1;
`endif
  localparam int PW = LAT + 1;

  logic        Clock;
  logic        Resetn;
  logic        Load;
  logic        Start;
  logic        Clear;
  logic [15:0] DIn;
  logic [3:0]  pc;
  logic [15:0] Instr;
  logic [4:0]  Count;
  logic        Ready;
  logic        Ovf;

  instr_loader #(.DB_CYCLES(DB)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Load  (Load),
    .Start (Start),
    .Clear (Clear),
    .DIn   (DIn),
    .pc    (pc),
    .Instr (Instr),
    .Count (Count),
    .Ready (Ready),
    .Ovf   (Ovf)
  );

  initial Clock = 1'b0;
  always #50 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: words are appended in order, memory is "ready" once
  // 16 words are in or Start arrives after at least one word.
  logic [15:0] m_mem [16];
  int          m_cnt;
  bit          m_rdy;
  bit          m_ovf;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_cnt = 0;
    m_rdy = 0;
    m_ovf = 0;
  endfunction

  function automatic void m_press(logic [15:0] d);
    if (m_rdy) m_ovf = 1;
    else begin
      m_mem[m_cnt] = d;
      m_cnt++;
      if (m_cnt == 16) m_rdy = 1;
    end
  endfunction

  function automatic void m_start();
    if (!m_rdy && m_cnt > 0) m_rdy = 1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".count"}, 32'(Count), 32'(m_cnt));
    chk({tag, ".ready"}, 32'(Ready), 32'(m_rdy));
    chk({tag, ".ovf"},   32'(Ovf),   32'(m_ovf));
    for (int p = 0; p < 16; p++) begin
      pc = 4'(p);
      #1;
      chk($sformatf("%s.instr[%0d]", tag, p), 32'(Instr),
          m_rdy ? 32'(m_mem[p]) : 32'd0);
    end
  endtask

  task automatic press(logic [15:0] d);
    DIn  = d;
    Load = 1'b1;
    repeat (PW) tick();
    Load = 1'b0;
    repeat (SETTLE) tick();
    m_press(d);
  endtask

  // Checks the exact write edge: nothing before LAT edges, written on edge LAT.
  task automatic press_checked(logic [15:0] d, int hold);
    DIn  = d;
    Load = 1'b1;
    repeat (LAT) tick();
    chk("latency.before", 32'(Count), 32'(m_cnt));
    tick();
    m_press(d);
    chk("latency.on_edge", 32'(Count), 32'(m_cnt));
    repeat (hold - LAT - 1) tick();
    Load = 1'b0;
    repeat (SETTLE) tick();
    check_all("press_checked");
  endtask

  task automatic press_start(logic [15:0] d);
    bit was_empty;
    was_empty = (m_cnt == 0 && !m_rdy);
    DIn  = d;
    Load = 1'b1;
    repeat (LAT) tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Load  = 1'b0;
    repeat (SETTLE) tick();
    m_press(d);
    if (!was_empty) m_start();
  endtask

  task automatic do_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    m_start();
  endtask

  task automatic do_clear(bit with_load);
    Clear = 1'b1;
    Load  = with_load;
    DIn   = 16'hFFFF;
    tick();
    Clear = 1'b0;
    Load  = 1'b0;
    repeat (SETTLE) tick();
    m_reset();
  endtask

  initial begin
    Resetn = 1'b0;
    Load   = 1'b0;
    Start  = 1'b0;
    Clear  = 1'b0;
    DIn    = '0;
    pc     = '0;
    m_reset();
    repeat (3) tick();
    check_all("reset");

`ifndef INSTR_LOADER_DEBOUNCE_EN
    // Key already down at reset release: no press on that edge or after.
    Resetn = 1'b1;
    Load   = 1'b1;
    tick();
    chk("release.no_press", 32'(Count), 32'd0);
    repeat (3) tick();
    chk("release.hold", 32'(Count), 32'd0);
    Load = 1'b0;
    tick();
`else
    Resetn = 1'b1;
    tick();
`endif

    // Full fill of 16 words.
    for (int i = 0; i < 16; i++) begin
      press(16'h1000 + 16'(i));
      chk($sformatf("fill.count%0d", i), 32'(Count), 32'(i + 1));
      if (i == 14) chk("fill.not_ready_at_15", 32'(Ready), 32'd0);
    end
    check_all("fill16");
    pc = 4'd5;
    #1;
    chk("fill16.pc5", 32'(Instr), 32'h1005);

    // Press while READY sets Ovf, memory untouched.
    press(16'hBEEF);
    chk("ovf.set", 32'(Ovf), 32'd1);
    check_all("ovf");

    // Clear wins over Load in the same cycle.
    do_clear(1'b1);
    check_all("clear_with_load");

    // Three words then Start.
    press(16'h1205);
    press(16'h2480);
    press(16'h3600);
    do_start();
    check_all("start3");
    pc = 4'd2;
    #1;
    chk("start3.pc2", 32'(Instr), 32'h3600);
    pc = 4'd9;
    #1;
    chk("start3.pc9", 32'(Instr), 32'h0000);

    // Start while EMPTY is ignored.
    do_clear(1'b0);
    do_start();
    check_all("start_in_empty");

    // Write latency, then Load held 20 cycles gives exactly one write.
    press_checked(16'hA001, PW);
    DIn  = 16'hA002;
    Load = 1'b1;
    repeat (20) tick();
    Load = 1'b0;
    repeat (SETTLE) tick();
    m_press(16'hA002);
    check_all("hold20");

    // Press and Start in the same cycle in FILLING: written, then READY.
    press_start(16'h7777);
    check_all("press_start");

    // Asynchronous reset after 7 writes.
    do_clear(1'b0);
    for (int i = 0; i < 7; i++) press(16'($urandom));
    chk("pre_reset.count", 32'(Count), 32'd7);
    #10;
    Resetn = 1'b0;
    #1;
    m_reset();
    chk("async_reset.count", 32'(Count), 32'd0);
    chk("async_reset.ready", 32'(Ready), 32'd0);
    check_all("async_reset");
    tick();
    Resetn = 1'b1;
    tick();
    press(16'h5A5A);
    do_start();
    check_all("after_reset_refill");

`ifdef INSTR_LOADER_DEBOUNCE_EN
    // Short glitch ignored; a 12-cycle press writes 10 cycles after the rise.
    do_clear(1'b0);
    Load = 1'b1;
    repeat (5) tick();
    Load = 1'b0;
    repeat (20) tick();
    chk("glitch.count", 32'(Count), 32'd0);
    press_checked(16'h4242, 12);
`endif

    // Randomized operation mix against the model.
    do_clear(1'b0);
    for (int n = 0; n < 200; n++) begin
      int unsigned op;
      op = $urandom_range(0, 11);
      if (op <= 6) press(16'($urandom));
      else if (op == 7) do_start();
      else if (op == 8) press_start(16'($urandom));
      else if (op == 9) do_clear(1'($urandom_range(0, 1)));
      else repeat ($urandom_range(1, 4)) tick();
      check_all($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 8: consecutive stable cycles required on Load before a press is accepted (used only with INSTR_LOADER_DEBOUNCE_EN).
REQ-002 The block SHALL have the port Clock, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have the port Resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port Load, input, 1 bit: key/switch level; each accepted rising edge writes one word.
REQ-005 The block SHALL have the port Start, input, 1 bit: level; ends filling early.
REQ-006 The block SHALL have the port Clear, input, 1 bit: level; empties the memory.
REQ-007 The block SHALL have the port DIn, input, 16 bits: instruction word from switches, {opcode[15:12], rA[11:9], rB[8:6], imm[5:0]}.
REQ-008 The block SHALL have the port pc, input, 4 bits: read address driven by the processor.
REQ-009 The block SHALL have the port Instr, output, 16 bits: instruction at pc.
REQ-010 The block SHALL have the port Count, output, 5 bits: words written, 0..16.
REQ-011 The block SHALL have the port Ready, output, 1 bit: memory is valid; drives the processor Run.
REQ-012 The block SHALL have the port Ovf, output, 1 bit: sticky flag, Load press accepted while READY.

Function
REQ-013 The block SHALL contain a 16x16 instruction memory with write pointer wr_ptr[3:0].
REQ-014 The FSM SHALL have three states: EMPTY, FILLING and READY.
REQ-015 In EMPTY, an accepted press SHALL write DIn to mem[0], set Count to 1 and move to FILLING; Start in EMPTY SHALL be ignored.
REQ-016 In FILLING, each accepted press SHALL write DIn to mem[wr_ptr] and increment wr_ptr and Count.
REQ-017 In FILLING, the write that brings Count to 16 SHALL move the FSM to READY; wr_ptr wraps to 0 and no further writes occur.
REQ-018 In FILLING, Start SHALL move the FSM to READY; entries not yet written keep 16'h0000, which decodes as mv R0,R0 (no-op).
REQ-019 If an accepted press and Start occur in the same cycle in FILLING, the word SHALL be written first and the FSM SHALL then enter READY.
REQ-020 In READY, presses SHALL NOT write memory and SHALL set Ovf, which stays set until Clear or reset.
REQ-021 Clear, in any state, SHALL zero all 16 entries, wr_ptr, Count and Ovf in one cycle and go to EMPTY.
REQ-022 Clear SHALL take priority over Load and Start in the same cycle.
REQ-023 Instr SHALL be a combinational read of mem[pc] when Ready=1, and 16'h0000 otherwise.
REQ-024 Ready SHALL be 1 exactly when the state is READY and SHALL be registered, changing on the clock edge of the transition.
REQ-025 Without debounce, a press SHALL be accepted on the first rising Clock edge where Load=1 and the registered previous Load=0, and the write SHALL occur on that same edge.
REQ-026 Holding Load high SHALL produce exactly one write.

Reset
REQ-027 Resetn=0 SHALL, asynchronously, set state EMPTY, wr_ptr=0, Count=0, Ready=0, Ovf=0 and all memory entries to 0, and SHALL clear synchronizer and debounce state.
REQ-028 The resulting combinational output SHALL be Instr=0.
REQ-029 Reset asserted mid-fill SHALL discard all words written so far.
REQ-030 Release of reset SHALL take effect on the next rising Clock edge; no press SHALL be accepted on that edge.

Configuration
REQ-031 With macro INSTR_LOADER_DEBOUNCE_EN defined, Load SHALL pass through a 2-flop synchronizer and a counter.
REQ-032 With INSTR_LOADER_DEBOUNCE_EN defined, the debounced level SHALL change only after the synchronized Load has held a new value for DB_CYCLES consecutive cycles.
REQ-033 With INSTR_LOADER_DEBOUNCE_EN defined, a press SHALL be accepted on the rising edge of the debounced level, so write latency from the Load rise is 2+DB_CYCLES cycles, and glitches shorter than DB_CYCLES SHALL be ignored.
REQ-034 Without INSTR_LOADER_DEBOUNCE_EN, the edge detect of REQ-025 SHALL apply directly to Load, with zero added latency.

Verification
REQ-035 The bench SHALL cover: reset, then 16 single-cycle Load pulses with DIn=16'h1000+i -> Count=16, Ready=1 after the 16th, Instr at pc=5 equals 16'h1005.
REQ-036 The bench SHALL cover: 3 pulses (DIn=16'h1205, 16'h2480, 16'h3600), then Start -> Ready=1, Count=3, Instr at pc=2 equals 16'h3600, Instr at pc=9 equals 16'h0000.
REQ-037 The bench SHALL cover: Load held high 20 cycles in FILLING -> exactly one write, Count increments by 1.
REQ-038 The bench SHALL cover: in READY, a Load pulse -> Ovf=1 and memory unchanged; then Clear with Load=1 in the same cycle -> EMPTY, Count=0, Ovf=0, no write.
REQ-039 The bench SHALL cover: Resetn pulsed low asynchronously after 7 writes -> Count=0, Ready=0 immediately, Instr=0 at all pc.
REQ-040 The bench SHALL cover, with INSTR_LOADER_DEBOUNCE_EN and DB_CYCLES=8: a 5-cycle Load glitch -> no write; a 12-cycle press -> one write, 10 cycles after the Load rise.
